// File: rtl/aes_pkg.sv
// Shared AES types and constants for the encrypt and decrypt byte-substitution stages.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [31:0]  aes_word_t;

  localparam int AES_BYTES = 16;

  // Substitution stage controller states: waiting for a block, or walking its four words.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SUB  = 1'b1
  } sub_state_e;

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box: one byte in, one byte out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input continuously.
module inv_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Full 256-entry inverse table, row-major on the high nibble of the input.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/inv_substitute.sv
// Inverse SubBytes over a 128-bit AES state, one 32-bit word per cycle through four shared inverse S-boxes.
// Latency: 4 cycles from the accepting load edge to the done pulse; one idle cycle between blocks (5-cycle issue interval).
// Backpressure: none; load is ignored while busy, so the caller must wait for busy to drop.
module inv_substitute
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  sub_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_block_t work_q, work_d;
  aes_block_t data_out_q, data_out_d;
  logic       done_q, done_d;

  aes_word_t  cur_word;
  aes_word_t  sub_word;

  // Select the word being substituted this cycle; word 0 is the most significant.
  always_comb begin
    cur_word = work_q[127:96];
    case (cnt_q)
      2'd0: cur_word = work_q[127:96];
      2'd1: cur_word = work_q[95:64];
      2'd2: cur_word = work_q[63:32];
      2'd3: cur_word = work_q[31:0];
      default: cur_word = work_q[127:96];
    endcase
  end

  // One inverse S-box per byte lane of the selected word.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .byte_i (cur_word[8*l +: 8]),
      .byte_o (sub_word[8*l +: 8])
    );
  end

  // Next-state and datapath update: accept in IDLE, walk four words in SUB, publish on the last.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          work_d  = data_in;
          cnt_d   = 2'd0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        case (cnt_q)
          2'd0: work_d[127:96] = sub_word;
          2'd1: work_d[95:64]  = sub_word;
          2'd2: work_d[63:32]  = sub_word;
          2'd3: work_d[31:0]   = sub_word;
          default: work_d = work_q;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Words 0..2 are already substituted in work_q; splice in the last one so the
          // output register updates once, with no partial result ever visible.
          data_out_d = {work_q[127:32], sub_word};
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      work_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign busy     = (state_q == ST_SUB);

endmodule

// File: tb/tb_inv_substitute.sv
module tb_inv_substitute;

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         busy;
  logic         done;

  int tests;
  int fails;
  int done_seen;
  int done_expected;
  logic [127:0] exp_q[$];

  localparam logic [127:0] KNOWN_IN  = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [127:0] KNOWN_OUT = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] ZERO_IN   = 128'h0;
  localparam logic [127:0] ZERO_OUT  = {16{8'h52}};
  localparam logic [127:0] ONES_IN   = {16{8'hFF}};
  localparam logic [127:0] ONES_OUT  = {16{8'h7D}};
  localparam logic [127:0] MIX_IN    = 128'h63636363_00000000_FFFFFFFF_52525252;
  localparam logic [127:0] MIX_OUT   = 128'h00000000_52525252_7D7D7D7D_48484848;

  inv_substitute #(.NUM_LANES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got data_out %h with no block outstanding", data_out);
      end else begin
        chk("result", data_out, exp_q.pop_front());
      end
    end
  end

  // Issue one block at the coming edge k and check busy/done timing through k+5.
  task automatic run_block(input logic [127:0] din, input logic [127:0] dexp);
    load    = 1'b1;
    data_in = din;
    exp_q.push_back(dexp);
    done_expected++;
    @(negedge clk);
    load = 1'b0;
    data_in = ~din;
    for (int i = 0; i < 4; i++) begin
      chk("busy_during", {127'd0, busy}, 128'd1);
      @(negedge clk);
    end
    chk("busy_after", {127'd0, busy}, 128'd0);
    chk("done_pulse", {127'd0, done}, 128'd1);
    @(negedge clk);
    chk("done_drop", {127'd0, done}, 128'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done_seen = 0;
    done_expected = 0;
    rst = 1'b1;
    load = 1'b1;
    data_in = {$urandom, $urandom, $urandom, $urandom};

    // Reset held with load asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_data_out", data_out, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_done", {127'd0, done}, 128'd0);
    end
    load = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_data_out", data_out, 128'd0);
      chk("post_rst_busy", {127'd0, busy}, 128'd0);
    end

    // Known vector, then hold check three cycles later.
    run_block(KNOWN_IN, KNOWN_OUT);
    chk("known_now", data_out, KNOWN_OUT);
    repeat (3) @(negedge clk);
    chk("known_held", data_out, KNOWN_OUT);

    // Table corners.
    run_block(ZERO_IN, ZERO_OUT);
    run_block(ONES_IN, ONES_OUT);
    run_block(MIX_IN, MIX_OUT);
    @(negedge clk);

    // Busy-ignore: second load two edges in must not start another block.
    load = 1'b1;
    data_in = KNOWN_IN;
    exp_q.push_back(KNOWN_OUT);
    done_expected++;
    @(negedge clk);               // edge k
    load = 1'b0;
    data_in = ZERO_IN;
    @(negedge clk);               // edge k+1
    load = 1'b1;                  // sampled at edge k+2 while busy
    @(negedge clk);               // edge k+2
    load = 1'b0;
    chk("ignore_busy", {127'd0, busy}, 128'd1);
    @(negedge clk);               // k+3
    @(negedge clk);               // k+4
    chk("ignore_done", {127'd0, done}, 128'd1);
    chk("ignore_data", data_out, KNOWN_OUT);
    repeat (6) @(negedge clk);
    chk("ignore_idle", {127'd0, busy}, 128'd0);

    // Back-to-back: load held for ten edges; accepted at k and k+5.
    load = 1'b1;
    data_in = ZERO_IN;
    exp_q.push_back(ZERO_OUT);
    done_expected++;
    @(negedge clk);               // edge k accepted ZERO_IN
    data_in = ONES_IN;
    exp_q.push_back(ONES_OUT);
    done_expected++;
    repeat (4) @(negedge clk);    // edges k+1..k+4
    chk("b2b_done1", {127'd0, done}, 128'd1);
    @(negedge clk);               // edge k+5 accepted ONES_IN
    chk("b2b_done1_drop", {127'd0, done}, 128'd0);
    chk("b2b_busy2", {127'd0, busy}, 128'd1);
    data_in = MIX_IN;
    repeat (4) @(negedge clk);    // edges k+6..k+9
    load = 1'b0;
    chk("b2b_done2", {127'd0, done}, 128'd1);
    @(negedge clk);               // edge k+10, load low: no third block
    chk("b2b_no_third", {127'd0, busy}, 128'd0);
    chk("b2b_done2_drop", {127'd0, done}, 128'd0);
    repeat (2) @(negedge clk);

    // Mid-operation reset between k+2 and k+3.
    load = 1'b1;
    data_in = MIX_IN;
    @(negedge clk);               // edge k
    load = 1'b0;
    repeat (2) @(negedge clk);    // edges k+1, k+2
    rst = 1'b1;
    #1;
    chk("abort_data_out", data_out, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done_data", data_out, 128'd0);
    run_block(KNOWN_IN, KNOWN_OUT);
    repeat (2) @(negedge clk);

    // Every issued block completed exactly once.
    chk("done_count", 128'(done_seen), 128'(done_expected));
    chk("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: guarantees termination even if the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
